// File: rtl/mod_i2c_slave.sv
// mod_i2c_slave: 7-bit I2C target with a small register file; no clock stretching.
// SCL/SDA are synchronised and edge-detected on clk; SDA is only ever pulled low or released.
module mod_i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h42,
  parameter int NREGS = 4,
  parameter int PTR_W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 SCL,
  inout  wire                  SDA,
  output logic [8*NREGS-1:0]   regs_flat,
  output logic                 wr_strobe,
  output logic [PTR_W-1:0]     wr_idx,
  output logic                 busy
);
  typedef enum logic [2:0] {IDLE, ADDR, PTR, WDATA, RDATA, MACK, IGNORE} state_t;
  state_t state, state_n;
  logic [2:0] scl_s, sda_s;
  logic [3:0] cnt, cnt_n;
  logic [7:0] shift, shift_n, byte_in, rd_byte;
  logic [PTR_W-1:0] ptr, ptr_n, ptr_inc;
  logic drive, drive_n, busy_n, rw, rw_n, wr_n;
  logic rise, fall, start, stop;
  assign SDA = drive ? 1'b0 : 1'bz;
  assign rise = scl_s[1] & ~scl_s[2];
  assign fall = ~scl_s[1] & scl_s[2];
  assign start = scl_s[1] & scl_s[2] & sda_s[2] & ~sda_s[1];
  assign stop = scl_s[1] & scl_s[2] & ~sda_s[2] & sda_s[1];
  assign byte_in = {shift[6:0], sda_s[1]};
  assign rd_byte = regs_flat[{ptr, 3'b000} +: 8];
  assign ptr_inc = ptr + PTR_W'(1);
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    shift_n = shift;
    drive_n = drive;
    busy_n = busy;
    rw_n = rw;
    ptr_n = ptr;
    wr_n = 1'b0;
    if (start) begin
      state_n = ADDR;
      cnt_n = 4'd0;
      drive_n = 1'b0;
      busy_n = 1'b0;
    end else if (stop) begin
      state_n = IDLE;
      drive_n = 1'b0;
      busy_n = 1'b0;
    end else begin
      case (state)
        ADDR, PTR, WDATA:
          if (rise && cnt < 4'd8) begin
            shift_n = byte_in;
            cnt_n = cnt + 4'd1;
            if (cnt == 4'd7) begin
              if (state == ADDR) begin
                if (byte_in[7:1] == SLAVE_ADDR) begin
                  busy_n = 1'b1;
                  rw_n = byte_in[0];
                end else state_n = IGNORE;
              end else if (state == PTR) ptr_n = byte_in[PTR_W-1:0];
              else begin
                wr_n = 1'b1;
                ptr_n = ptr_inc;
              end
            end
          end else if (fall && cnt == 4'd8) begin
            drive_n = 1'b1;
            cnt_n = 4'd9;
          end else if (fall && cnt == 4'd9) begin
            cnt_n = 4'd0;
            drive_n = 1'b0;
            state_n = state != ADDR ? WDATA : rw ? RDATA : PTR;
            // A read starts shifting out on the very edge that ends the address ACK
            if (state == ADDR && rw) begin
              shift_n = {rd_byte[6:0], 1'b0};
              drive_n = ~rd_byte[7];
              cnt_n = 4'd1;
            end
          end
        RDATA:
          if (fall) begin
            if (cnt == 4'd0) begin
              shift_n = {rd_byte[6:0], 1'b0};
              drive_n = ~rd_byte[7];
              cnt_n = 4'd1;
            end else if (cnt < 4'd8) begin
              shift_n = {shift[6:0], 1'b0};
              drive_n = ~shift[7];
              cnt_n = cnt + 4'd1;
            end else begin
              drive_n = 1'b0;
              state_n = MACK;
            end
          end
        MACK:
          if (rise) begin
            ptr_n = ptr_inc;
            cnt_n = 4'd0;
            state_n = sda_s[1] ? IGNORE : RDATA;
            busy_n = busy & ~sda_s[1];
          end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_s <= 3'b111;
      sda_s <= 3'b111;
      state <= IDLE;
      cnt <= 4'd0;
      shift <= 8'd0;
      drive <= 1'b0;
      busy <= 1'b0;
      rw <= 1'b0;
      ptr <= '0;
      regs_flat <= '0;
      wr_strobe <= 1'b0;
      wr_idx <= '0;
    end else begin
      scl_s <= {scl_s[1:0], SCL};
      sda_s <= {sda_s[1:0], SDA};
      state <= state_n;
      cnt <= cnt_n;
      shift <= shift_n;
      drive <= drive_n;
      busy <= busy_n;
      rw <= rw_n;
      ptr <= ptr_n;
      wr_strobe <= wr_n;
      if (wr_n) begin
        regs_flat[{ptr, 3'b000} +: 8] <= byte_in;
        wr_idx <= ptr;
      end
    end
  end
endmodule

// File: tb/tb_mod_i2c_slave.sv
// tb_mod_i2c_slave: bit-banged I2C master with write/read scoreboards against mod_i2c_slave.
module tb_mod_i2c_slave;
  localparam time Q = 100;
  logic clk = 1'b0, rst = 1'b1, scl = 1'b1, m_sda = 1'b1;
  wire sda;
  logic [31:0] regs_flat;
  logic wr_strobe, busy;
  logic [1:0] wr_idx;
  int n_cmp = 0, n_bad = 0, n_strobe = 0, n_drive = 0;
  logic [7:0] model [4];
  logic [9:0] wq [$];
  logic [7:0] rq [$];
  logic [9:0] we;
  pullup (sda);
  assign sda = m_sda ? 1'bz : 1'b0;
  always #5 clk = ~clk;
  mod_i2c_slave dut (.clk(clk), .rst(rst), .SCL(scl), .SDA(sda), .regs_flat(regs_flat),
                     .wr_strobe(wr_strobe), .wr_idx(wr_idx), .busy(busy));
  // Write scoreboard: every strobe must match the next expected {idx,data}
  always @(negedge clk) begin
    if (m_sda && sda === 1'b0) n_drive++;
    if (wr_strobe) begin
      n_strobe++;
      n_cmp++;
      if (wq.size() == 0) begin
        n_bad++;
        $display("FAIL wr_strobe_unexpected idx=%0d", wr_idx);
      end else begin
        we = wq.pop_front();
        if (wr_idx !== we[9:8] || regs_flat[wr_idx*8 +: 8] !== we[7:0]) begin
          n_bad++;
          $display("FAIL wr_commit got idx=%0d data=%h exp idx=%0d data=%h",
                   wr_idx, regs_flat[wr_idx*8 +: 8], we[9:8], we[7:0]);
        end
      end
    end
  end
  task automatic sbit(input logic b);
    m_sda = b; #Q scl = 1; #(2*Q) scl = 0; #Q;
  endtask
  task automatic start_c;
    m_sda = 1; #Q scl = 1; #Q m_sda = 0; #Q scl = 0; #Q;
  endtask
  task automatic stop_c;
    m_sda = 0; #Q scl = 1; #Q m_sda = 1; #Q;
  endtask
  task automatic wbyte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) sbit(b[i]);
    m_sda = 1; #Q scl = 1; #Q ack = sda; #Q scl = 0; #Q;
  endtask
  task automatic rbyte(input logic nack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      m_sda = 1; #Q scl = 1; #Q b[i] = sda; #Q scl = 0; #Q;
    end
    sbit(nack);
  endtask
  task automatic write_txn(input logic [7:0] p, input logic [7:0] d0, input logic [7:0] d1,
                           input int nd, input string nm);
    logic [7:0] bytes [4];
    logic a;
    logic [1:0] idx;
    bytes = '{8'h84, p, d0, d1};
    idx = p[1:0];
    start_c;
    for (int i = 0; i < nd + 2; i++) begin
      if (i >= 2) begin
        wq.push_back({idx, bytes[i]});
        model[idx] = bytes[i];
        idx = idx + 2'd1;
      end
      wbyte(bytes[i], a);
      n_cmp++;
      if (a !== 1'b0) begin
        n_bad++;
        $display("FAIL %s_ack%0d got=%b exp=0", nm, i, a);
      end
    end
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_busy got=%b exp=1", nm, busy);
    end
    stop_c;
    #(4*Q);
  endtask
  task automatic check_regs(input string nm);
    n_cmp++;
    if (wq.size() != 0) begin
      n_bad++;
      $display("FAIL %s_missing_strobes got=%0d pending exp=0", nm, wq.size());
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_busy_after got=%b exp=0", nm, busy);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (regs_flat[i*8 +: 8] !== model[i]) begin
        n_bad++;
        $display("FAIL %s_reg%0d got=%h exp=%h", nm, i, regs_flat[i*8 +: 8], model[i]);
      end
    end
  endtask
  task automatic test_reset;
    for (int i = 0; i < 4; i++) model[i] = 8'h00;
    #23;
    n_cmp++;
    if (regs_flat !== 32'h0 || busy !== 1'b0 || wr_strobe !== 1'b0 || wr_idx !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_outputs got regs=%h busy=%b strobe=%b idx=%0d exp 0", regs_flat, busy, wr_strobe, wr_idx);
    end
    n_cmp++;
    if (sda !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_sda got=%b exp=1", sda);
    end
    rst = 0;
    #50;
  endtask
  task automatic test_write;
    int s0;
    s0 = n_strobe;
    write_txn(8'h01, 8'hA5, 8'h00, 1, "write");
    check_regs("write");
    n_cmp++;
    if (n_strobe - s0 != 1) begin
      n_bad++;
      $display("FAIL write_strobe_count got=%0d exp=1", n_strobe - s0);
    end
  endtask
  task automatic test_burst_wrap;
    int s0;
    s0 = n_strobe;
    write_txn(8'h03, 8'h11, 8'h22, 2, "burst");
    check_regs("burst");
    n_cmp++;
    if (n_strobe - s0 != 2) begin
      n_bad++;
      $display("FAIL burst_strobe_count got=%0d exp=2", n_strobe - s0);
    end
  endtask
  task automatic test_back_to_back;
    write_txn(8'hF2, 8'hC3, 8'h00, 1, "b2b_a");
    write_txn(8'h00, 8'h77, 8'h00, 1, "b2b_b");
    check_regs("b2b");
  endtask
  task automatic test_read;
    logic a;
    logic [7:0] d, e;
    logic [7:0] wbytes [2];
    wbytes = '{8'h84, 8'h01};
    start_c;
    for (int i = 0; i < 2; i++) begin
      wbyte(wbytes[i], a);
      n_cmp++;
      if (a !== 1'b0) begin
        n_bad++;
        $display("FAIL read_setup_ack%0d got=%b exp=0", i, a);
      end
    end
    start_c;
    wbyte(8'h85, a);
    n_cmp++;
    if (a !== 1'b0) begin
      n_bad++;
      $display("FAIL read_addr_ack got=%b exp=0", a);
    end
    rq.push_back(model[1]);
    rq.push_back(model[2]);
    for (int i = 0; i < 2; i++) begin
      rbyte(i == 1, d);
      e = rq.pop_front();
      n_cmp++;
      if (d !== e) begin
        n_bad++;
        $display("FAIL read_byte%0d got=%h exp=%h", i, d, e);
      end
      if (i == 0) begin
        n_cmp++;
        if (busy !== 1'b1) begin
          n_bad++;
          $display("FAIL read_busy got=%b exp=1", busy);
        end
      end
    end
    #Q;
    n_cmp++;
    if (sda !== 1'b1) begin
      n_bad++;
      $display("FAIL read_sda_after_nack got=%b exp=1", sda);
    end
    stop_c;
    #(4*Q);
    check_regs("read");
  endtask
  task automatic test_mismatch(input logic [7:0] addr, input string nm);
    logic a;
    int d0;
    d0 = n_drive;
    start_c;
    wbyte(addr, a);
    n_cmp++;
    if (a !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_nack got=%b exp=1", nm, a);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_busy got=%b exp=0", nm, busy);
    end
    wbyte(8'h55, a);
    stop_c;
    #(4*Q);
    n_cmp++;
    if (n_drive != d0) begin
      n_bad++;
      $display("FAIL %s_sda_driven got=%0d low cycles exp=0", nm, n_drive - d0);
    end
    check_regs(nm);
  endtask
  task automatic test_abort;
    logic [7:0] b;
    b = 8'h84;
    start_c;
    for (int i = 7; i >= 0; i--) sbit(b[i]);
    m_sda = 1;
    #20;
    n_cmp++;
    if (sda !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_ack_driven got=%b exp=0", sda);
    end
    rst = 1;
    #1;
    n_cmp++;
    if (sda !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_sda_release got=%b exp=1", sda);
    end
    for (int i = 0; i < 4; i++) model[i] = 8'h00;
    #Q scl = 1;
    #Q rst = 0;
    #Q;
    check_regs("abort_cleared");
    write_txn(8'h02, 8'h5A, 8'h00, 1, "abort_wr");
    check_regs("abort_wr");
  endtask
  initial begin
    test_reset;
    test_write;
    test_burst_wrap;
    test_back_to_back;
    test_read;
    test_mismatch(8'h90, "mismatch");
    test_mismatch(8'h00, "gencall");
    test_abort;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
